// File: rtl/wb_block_copy.sv
// wb_block_copy
//   Copies a block of 32-bit words from one word address to another over a
//   pipelined Wishbone master port: read one word, write it, repeat.
//
//   Ports
//     clk_i, rst_ni             : clock, asynchronous active-low reset
//     start_i                   : one-cycle launch pulse (accepted only when idle)
//     src_addr_i, dst_addr_i    : first source / destination word address
//     len_i                     : word count, 0 = no transfer
//     busy_o                    : copy in progress
//     done_o                    : one-cycle completion (or abort) pulse
//     err_o                     : sticky ack-timeout flag, cleared by next start
//     wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o : Wishbone request
//     wb_data_i, wb_ack_i, wb_stall_i                   : Wishbone response
module wb_block_copy #(
  parameter int ADDR_W      = 11,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [31:0]       wb_data_o,
  input  logic [31:0]       wb_data_i,
  input  logic              wb_ack_i,
  input  logic              wb_stall_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
  } state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] srcAddr, dstAddr, remain;
  logic [31:0]       dataReg;
  logic [CNT_W-1:0]  waitCnt;
  logic              inWait, timeout;

  assign inWait  = (state == RD_WAIT) || (state == WR_WAIT);
  // Last permitted wait cycle without an ack: give up at the next edge.
  assign timeout = inWait && !wb_ack_i && (waitCnt == WAIT_LAST);

  // Bus outputs decode straight from state so an asynchronous reset drops
  // the request in the same cycle.
  assign wb_stb_o  = (state == RD_REQ) || (state == WR_REQ);
  assign wb_we_o   = (state == WR_REQ);
  assign wb_sel_o  = 4'b1111;
  assign wb_addr_o = (state == WR_REQ) ? dstAddr : srcAddr;
  assign wb_data_o = dataReg;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start_i) nextState = (len_i == '0) ? FINISH : RD_REQ;
      RD_REQ:  if (!wb_stall_i) nextState = RD_WAIT;
      RD_WAIT: begin
        if (wb_ack_i)     nextState = WR_REQ;
        else if (timeout) nextState = FINISH;
      end
      WR_REQ:  if (!wb_stall_i) nextState = WR_WAIT;
      WR_WAIT: begin
        if (wb_ack_i)     nextState = (remain == ADDR_W'(1)) ? FINISH : RD_REQ;
        else if (timeout) nextState = FINISH;
      end
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      srcAddr <= '0;
      dstAddr <= '0;
      remain  <= '0;
      dataReg <= '0;
      waitCnt <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state  <= nextState;
      // done is registered off FINISH, so it lands one cycle after FINISH,
      // and busy falls on that same cycle.
      done_o <= (state == FINISH);
      if (state == FINISH) busy_o <= 1'b0;

      // Wait counter restarts on every entry into a wait state.
      if (inWait && (nextState == state)) waitCnt <= waitCnt + CNT_W'(1);
      else                                waitCnt <= '0;

      if (state == IDLE && start_i) begin
        srcAddr <= src_addr_i;
        dstAddr <= dst_addr_i;
        remain  <= len_i;
        err_o   <= 1'b0;
        busy_o  <= 1'b1;
      end

      if (state == RD_WAIT && wb_ack_i) dataReg <= wb_data_i;

      // Addresses wrap naturally at ADDR_W bits; the count is independent.
      if (state == WR_WAIT && wb_ack_i) begin
        srcAddr <= srcAddr + ADDR_W'(1);
        dstAddr <= dstAddr + ADDR_W'(1);
        remain  <= remain - ADDR_W'(1);
      end

      if (timeout) err_o <= 1'b1;
    end
  end

endmodule
